// File: rtl/led7_scan_decoder_pkg.sv
// Shared types, widths and helpers for the 7-segment scan decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package led7_scan_decoder_pkg;

  // Run counter width covers the largest stability window (255).
  localparam int CNT_W = 8;
  // Width of one decoded BCD digit.
  localparam int VAL_W = 4;

  // One decoded digit: BCD value plus its legality flag.
  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             legal;
  } digit_t;

  // Next run length: restart at 1 on any change, otherwise count up and saturate at the limit.
  function automatic logic [CNT_W-1:0] f_run_next(
    input logic [CNT_W-1:0] cnt,
    input logic             same,
    input logic [CNT_W-1:0] limit
  );
    if (!same) return CNT_W'(1);
    if (cnt >= limit) return limit;
    return cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/led7_defs.vh
// Segment patterns shared by the 7-segment encoder and decoder.
// Bit order is gfedcba: bit0 = segment a ... bit6 = segment g, active-high.
// LED7_ILLEGAL is the value reported for any unrecognised pattern.
`ifndef LED7_DEFS_VH
`define LED7_DEFS_VH

`define LED7_PAT_0 7'b0111111
`define LED7_PAT_1 7'b0000110
`define LED7_PAT_2 7'b1011011
`define LED7_PAT_3 7'b1001111
`define LED7_PAT_4 7'b1100110
`define LED7_PAT_5 7'b1101101
`define LED7_PAT_6 7'b1111101
`define LED7_PAT_7 7'b0000111
`define LED7_PAT_8 7'b1111111
`define LED7_PAT_9 7'b1100111

`define LED7_ILLEGAL 4'hF

`endif

// File: rtl/led7_seg_decode.sv
// Decodes one 7-segment pattern into a BCD value and a legality flag.
// Latency: purely combinational.
// Backpressure: none; output follows the input.
`include "led7_defs.vh"

module led7_seg_decode
  import led7_scan_decoder_pkg::*;
(
  input  logic [6:0]       i_w_seg,
  output logic [VAL_W-1:0] o_w_value,
  output logic             o_w_legal
);

  // Table lookup; anything that is not one of the ten digit shapes is flagged illegal.
  always_comb begin
    o_w_value = `LED7_ILLEGAL;
    o_w_legal = 1'b1;
    case (i_w_seg)
      `LED7_PAT_0: o_w_value = 4'd0;
      `LED7_PAT_1: o_w_value = 4'd1;
      `LED7_PAT_2: o_w_value = 4'd2;
      `LED7_PAT_3: o_w_value = 4'd3;
      `LED7_PAT_4: o_w_value = 4'd4;
      `LED7_PAT_5: o_w_value = 4'd5;
      `LED7_PAT_6: o_w_value = 4'd6;
      `LED7_PAT_7: o_w_value = 4'd7;
      `LED7_PAT_8: o_w_value = 4'd8;
      `LED7_PAT_9: o_w_value = 4'd9;
      default: begin
        o_w_value = `LED7_ILLEGAL;
        o_w_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/led7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus and presents whole frames.
// Latency: a digit commits STABLE_CYCLES edges after it appears; its frame is presented on that same edge.
// Backpressure: frame held until i_w_frame_ready; a frame completing while one is pending is dropped (o_w_overrun).
module led7_scan_decoder
  import led7_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                i_w_clk,
  input  logic                i_w_reset,
  input  logic [6:0]          i_w_seg,
  input  logic [DIGITS-1:0]   i_w_an,
  input  logic                i_w_frame_ready,
  output logic [4*DIGITS-1:0] o_w_frame,
  output logic [DIGITS-1:0]   o_w_frame_legal,
  output logic                o_w_frame_valid,
  output logic                o_w_error,
  output logic                o_w_overrun
);

  localparam int               SMP_W    = DIGITS + 7;
  localparam logic [CNT_W-1:0] L_STABLE = CNT_W'(STABLE_CYCLES);

  // Registered state.
  logic [SMP_W-1:0]    r_sample;
  logic [CNT_W-1:0]    r_run_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_stage_val;
  logic [DIGITS-1:0]   r_stage_legal;
  logic [4*DIGITS-1:0] r_frame;
  logic [DIGITS-1:0]   r_frame_legal;
  logic                r_frame_valid;
  logic                r_error;
  logic                r_overrun;

  // Combinational next-state and decode.
  logic [SMP_W-1:0]    w_sample_in;
  logic                w_same;
  logic [CNT_W-1:0]    w_run_nxt;
  logic                w_commit;
  logic                w_an_onehot;
  logic                w_an_multi;
  logic                w_digit_commit;
  logic [VAL_W-1:0]    w_dec_value;
  logic                w_dec_legal;
  digit_t              w_dec;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic [4*DIGITS-1:0] w_stage_val_nxt;
  logic [DIGITS-1:0]   w_stage_legal_nxt;
  logic                w_complete;
  logic                w_load;

  assign w_sample_in = {i_w_an, i_w_seg};

  led7_seg_decode u_seg_decode (
    .i_w_seg   (i_w_seg),
    .o_w_value (w_dec_value),
    .o_w_legal (w_dec_legal)
  );

  assign w_dec = '{value: w_dec_value, legal: w_dec_legal};

  // Run length of the current bus value; commit exactly once per run when it reaches the window.
  // The "not already saturated" term lets a one-cycle window commit on every change but not on a hold.
  always_comb begin
    w_same    = (w_sample_in == r_sample);
    w_run_nxt = f_run_next(r_run_cnt, w_same, L_STABLE);
    w_commit  = (w_run_nxt == L_STABLE) && (!w_same || (r_run_cnt != L_STABLE));
  end

  // Merge a committed one-hot digit into staging and detect a completed frame on the same edge.
  always_comb begin
    w_an_onehot       = $onehot(i_w_an);
    w_an_multi        = (i_w_an != '0) && !w_an_onehot;
    w_digit_commit    = w_commit && w_an_onehot;
    w_stage_val_nxt   = r_stage_val;
    w_stage_legal_nxt = r_stage_legal;
    w_seen_nxt        = r_seen;
    if (w_digit_commit) begin
      w_seen_nxt = r_seen | i_w_an;
      for (int k = 0; k < DIGITS; k++) begin
        if (i_w_an[k]) begin
          w_stage_val_nxt[4*k +: 4] = w_dec.value;
          w_stage_legal_nxt[k]      = w_dec.legal;
        end
      end
    end
    w_complete = w_digit_commit && (&w_seen_nxt);
    w_load     = w_complete && (!r_frame_valid || i_w_frame_ready);
  end

  // Sample the bus every edge and track how long it has been steady.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_sample  <= '0;
      r_run_cnt <= '0;
    end else begin
      r_sample  <= w_sample_in;
      r_run_cnt <= w_run_nxt;
    end
  end

  // Accumulate committed digits; the seen mask restarts once a frame is complete.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_seen        <= '0;
      r_stage_val   <= '0;
      r_stage_legal <= '0;
    end else begin
      r_seen        <= w_complete ? '0 : w_seen_nxt;
      r_stage_val   <= w_stage_val_nxt;
      r_stage_legal <= w_stage_legal_nxt;
    end
  end

  // Output frame handshake plus one-cycle error and overrun pulses.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_frame       <= '0;
      r_frame_legal <= '0;
      r_frame_valid <= 1'b0;
      r_error       <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_error   <= w_commit && w_an_multi;
      r_overrun <= w_complete && !w_load;
      if (w_load) begin
        r_frame       <= w_stage_val_nxt;
        r_frame_legal <= w_stage_legal_nxt;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && i_w_frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign o_w_frame       = r_frame;
  assign o_w_frame_legal = r_frame_legal;
  assign o_w_frame_valid = r_frame_valid;
  assign o_w_error       = r_error;
  assign o_w_overrun     = r_overrun;

endmodule

// File: tb/tb_led7_scan_decoder.sv
// Bench for led7_scan_decoder: two instances (3-cycle and 1-cycle windows) share one bus.
// Latency: n/a.
// Backpressure: ready is driven directly by the stimulus.
module tb_led7_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        rdy;

  logic [15:0] a_frame, b_frame;
  logic [3:0]  a_legal, b_legal;
  logic        a_valid, b_valid, a_err, b_err, a_ovr, b_ovr;

  int checks = 0;
  int errors = 0;

  led7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(3)) u_dut_a (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_seg(seg), .i_w_an(an), .i_w_frame_ready(rdy),
    .o_w_frame(a_frame), .o_w_frame_legal(a_legal), .o_w_frame_valid(a_valid),
    .o_w_error(a_err), .o_w_overrun(a_ovr)
  );

  led7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(1)) u_dut_b (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_seg(seg), .i_w_an(an), .i_w_frame_ready(rdy),
    .o_w_frame(b_frame), .o_w_frame_legal(b_legal), .o_w_frame_valid(b_valid),
    .o_w_error(b_err), .o_w_overrun(b_ovr)
  );

  // Reference model state, one slot per instance.
  int          stab [2] = '{3, 1};
  logic [3:0]  prev_an [2];
  logic [6:0]  prev_seg [2];
  int          run [2];
  logic [3:0]  seen [2];
  logic [3:0]  sval [2][4];
  logic [3:0]  slegal [2];
  logic [15:0] mframe [2];
  logic [3:0]  mlegal [2];
  logic        mvalid [2];
  logic        merr [2];
  logic        movr [2];
  logic [6:0]  pats [10];

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (pats[d] == s) return {1'b1, 4'(d)};
    return {1'b0, 4'hF};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      prev_an[u] = '0; prev_seg[u] = '0; run[u] = 0; seen[u] = '0; slegal[u] = '0;
      mframe[u] = '0; mlegal[u] = '0; mvalid[u] = 1'b0; merr[u] = 1'b0; movr[u] = 1'b0;
      for (int i = 0; i < 4; i++) sval[u][i] = '0;
    end
  endtask

  // One clock edge of the reference: a value counts once it has been present for exactly stab edges.
  task automatic model_edge(input int u, input logic [3:0] a, input logic [6:0] s, input logic r);
    logic [4:0] dv;
    logic       complete;
    merr[u] = 1'b0; movr[u] = 1'b0; complete = 1'b0;
    if (a == prev_an[u] && s == prev_seg[u]) begin
      if (run[u] < 1000) run[u]++;
    end else begin
      run[u] = 1;
    end
    prev_an[u] = a; prev_seg[u] = s;
    if (run[u] == stab[u]) begin
      if ($countones(a) == 1) begin
        dv = ref_decode(s);
        for (int i = 0; i < 4; i++) if (a[i]) begin sval[u][i] = dv[3:0]; slegal[u][i] = dv[4]; end
        seen[u] = seen[u] | a;
        if (seen[u] == 4'hF) begin complete = 1'b1; seen[u] = '0; end
      end else if ($countones(a) > 1) begin
        merr[u] = 1'b1;
      end
    end
    if (complete) begin
      if (!mvalid[u] || r) begin
        for (int i = 0; i < 4; i++) mframe[u][4*i +: 4] = sval[u][i];
        mlegal[u] = slegal[u];
        mvalid[u] = 1'b1;
      end else begin
        movr[u] = 1'b1;
      end
    end else if (mvalid[u] && r) begin
      mvalid[u] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_valid", a_valid, mvalid[0]);
    chk("a_frame", a_frame, mframe[0]);
    chk("a_legal", a_legal, mlegal[0]);
    chk("a_error", a_err, merr[0]);
    chk("a_overrun", a_ovr, movr[0]);
    chk("b_valid", b_valid, mvalid[1]);
    chk("b_frame", b_frame, mframe[1]);
    chk("b_legal", b_legal, mlegal[1]);
    chk("b_error", b_err, merr[1]);
    chk("b_overrun", b_ovr, movr[1]);
  endtask

  // Drive inputs between edges, let one edge pass, then compare just after it.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r);
    an = a; seg = s; rdy = r;
    @(posedge clk);
    model_edge(0, a, s, r);
    model_edge(1, a, s, r);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic r, input int n);
    for (int i = 0; i < n; i++) step(a, s, r);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         kind;
    int         len;

    pats[0] = 7'b0111111; pats[1] = 7'b0000110; pats[2] = 7'b1011011; pats[3] = 7'b1001111;
    pats[4] = 7'b1100110; pats[5] = 7'b1101101; pats[6] = 7'b1111101; pats[7] = 7'b0000111;
    pats[8] = 7'b1111111; pats[9] = 7'b1100111;
    model_reset();
    rst = 1'b1; an = '0; seg = '0; rdy = 1'b0;
    #12;
    chk("rst_valid", a_valid, 0);
    chk("rst_frame", a_frame, 0);
    chk("rst_legal", a_legal, 0);
    chk("rst_error", a_err, 0);
    chk("rst_overrun", a_ovr, 0);
    rst = 1'b0;

    // Frame capture: 2,1,8,0 each held four edges, consumer always ready.
    hold(4'b0001, 7'b1011011, 1'b1, 4);
    hold(4'b0010, 7'b0000110, 1'b1, 4);
    hold(4'b0100, 7'b1111111, 1'b1, 4);
    hold(4'b1000, 7'b0111111, 1'b1, 3);
    chk("cap_valid", a_valid, 1);
    chk("cap_frame", a_frame, 16'h0812);
    chk("cap_legal", a_legal, 4'hF);
    step(4'b1000, 7'b0111111, 1'b1);
    chk("cap_drop", a_valid, 0);

    // Glitch: digit 2 shown for only two edges is not accepted.
    hold(4'b0001, 7'b1011011, 1'b0, 4);
    hold(4'b0010, 7'b0000110, 1'b0, 4);
    hold(4'b0100, 7'b1111111, 1'b0, 2);
    hold(4'b1000, 7'b0111111, 1'b0, 4);
    chk("glitch_novalid", a_valid, 0);
    hold(4'b0100, 7'b1111111, 1'b0, 3);
    chk("glitch_valid", a_valid, 1);
    chk("glitch_frame", a_frame, 16'h0812);

    // Backpressure: second frame (3,4,5,6) completes while the first is unaccepted.
    hold(4'b0001, 7'b1001111, 1'b0, 4);
    hold(4'b0010, 7'b1100110, 1'b0, 4);
    hold(4'b0100, 7'b1101101, 1'b0, 4);
    hold(4'b1000, 7'b1111101, 1'b0, 3);
    chk("ovr_pulse", a_ovr, 1);
    chk("ovr_frame", a_frame, 16'h0812);
    chk("ovr_valid", a_valid, 1);
    step(4'b1000, 7'b1111101, 1'b0);
    chk("ovr_clear", a_ovr, 0);

    // Third frame (7,9,3,4) completes on the same edge the old one is accepted.
    hold(4'b0001, 7'b0000111, 1'b0, 4);
    hold(4'b0010, 7'b1100111, 1'b0, 4);
    hold(4'b0100, 7'b1001111, 1'b0, 4);
    hold(4'b1000, 7'b1100110, 1'b0, 2);
    step(4'b1000, 7'b1100110, 1'b1);
    chk("load_valid", a_valid, 1);
    chk("load_frame", a_frame, 16'h4397);
    chk("load_noovr", a_ovr, 0);
    step(4'b1000, 7'b1100110, 1'b1);
    chk("load_drop", a_valid, 0);

    // Multi-hot anode: one error pulse and no digit accepted; then an illegal digit 0.
    hold(4'b0011, 7'b1011011, 1'b1, 2);
    chk("multi_pre", a_err, 0);
    step(4'b0011, 7'b1011011, 1'b1);
    chk("multi_err", a_err, 1);
    step(4'b0010, 7'b0000110, 1'b1);
    chk("multi_once", a_err, 0);
    hold(4'b0010, 7'b0000110, 1'b1, 3);
    hold(4'b0100, 7'b1111111, 1'b1, 4);
    hold(4'b1000, 7'b0111111, 1'b1, 4);
    chk("multi_noseen", a_valid, 0);
    hold(4'b0001, 7'b0000001, 1'b0, 3);
    chk("ill_valid", a_valid, 1);
    chk("ill_frame", a_frame, 16'h081F);
    chk("ill_legal", a_legal, 4'b1110);

    // Asynchronous reset after two digits of a new frame; partial capture is lost.
    hold(4'b0010, 7'b0000110, 1'b0, 4);
    hold(4'b0100, 7'b1011011, 1'b0, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_frame", a_frame, 0);
    chk("arst_legal", a_legal, 0);
    chk("arst_b_valid", b_valid, 0);
    model_reset();
    #1 rst = 1'b0;
    hold(4'b0001, 7'b0111111, 1'b0, 4);
    hold(4'b1000, 7'b0111111, 1'b0, 4);
    chk("arst_partial", a_valid, 0);
    hold(4'b0010, 7'b0000110, 1'b0, 4);
    hold(4'b0100, 7'b1011011, 1'b0, 4);
    chk("arst_refill", a_valid, 1);
    chk("arst_frame2", a_frame, 16'h0210);

    // Randomized bus traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) ra = 4'b0000;
      else if (kind == 1) ra = 4'b0011 << $urandom_range(0, 2);
      else ra = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 6) == 0) rs = 7'($urandom);
      else rs = pats[$urandom_range(0, 9)];
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) step(ra, rs, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
